lbp_scan_ctrl: RTL
==================

LBP_SCAN_CTRL -- requirements
Module: lbp_scan_ctrl

Interface
REQ-001 Parameter IMG_W, 128, image width in pixels (power of two, >=4).
REQ-002 Parameter IMG_H, 128, image height in pixels (>=3); N = IMG_W*IMG_H <= 16384.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 RGB_ready  in  1  host has RGB data available.
REQ-006 RGB_req  out  1  request RGB pixel at RGB_addr this cycle.
REQ-007 RGB_addr  out  14  raster index of requested RGB pixel.
REQ-008 gray_valid  out  1  datapath writes converted gray pixel this cycle.
REQ-009 gray_addr  out  14  raster index of gray write.
REQ-010 nb_rd  out  1  gray-buffer read strobe for LBP window.
REQ-011 nb_addr  out  14  gray-buffer read index.
REQ-012 nb_sel  out  4  window slot of current read: 0 centre, 1..8 neighbours.
REQ-013 lbp_valid  out  1  datapath emits LBP result this cycle.
REQ-014 lbp_addr  out  14  raster index of LBP result.
REQ-015 lbp_zero  out  1  force LBP result to 0 (border pixel).
REQ-016 finish  out  1  whole frame done.

Function
REQ-017 FSM states IDLE, LOAD, READ, WAIT, EMIT, BORDER, DONE; IDLE -> LOAD unconditionally on first clock after reset release.
REQ-018 LOAD: RGB_req = RGB_ready; RGB_addr = k, k increments only on cycles with RGB_req=1; RGB_ready=0 holds k, RGB_req=0.
REQ-019 gray_valid/gray_addr = registered RGB_req/RGB_addr (latency 1 cycle).
REQ-020 LOAD exits after request k=N-1 issued, then one drain cycle for its gray write; next pixel p=0.
REQ-021 Border pixel (row 0, row IMG_H-1, col 0, col IMG_W-1): state BORDER, one cycle, lbp_valid=1, lbp_zero=1, lbp_addr=p, no nb_rd.
REQ-022 Interior pixel: READ for 9 cycles, nb_rd=1, nb_sel 0..8, offsets 0,-W-1,-W,-W+1,-1,+1,+W-1,+W,+W+1 (W=IMG_W).
REQ-023 Read data returns 1 cycle after nb_rd; WAIT covers last return; EMIT asserts lbp_valid=1, lbp_zero=0, lbp_addr=p; 11 cycles/interior pixel.
REQ-024 After pixel N-1 emitted -> DONE; finish=1 held until reset; no further strobes.
REQ-025 All strobes single-cycle pulses; address outputs hold last value when strobe low.
REQ-026 Address arithmetic 14-bit unsigned; interior classification guarantees no wrap-around.

Reset
REQ-027 On reset all outputs 0, FSM IDLE, counters 0, independent of state; reset mid-frame aborts and restarts frame from RGB pixel 0.

Configuration
REQ-028 Macro LBP_BORDER_ZERO_EN defined: border handling per REQ-021.
REQ-029 Macro LBP_BORDER_ZERO_EN undefined: border pixels skipped in 0 cycles, no lbp_valid for them, lbp_zero tied 0.

Structure
REQ-030 Package lbp_pkg: state enum, default IMG_W/IMG_H, neighbour-offset table indexed by nb_sel.
REQ-031 One sub-module lbp_nb_addr_gen: combinational (p, nb_sel) -> nb_addr plus border flag.

Verification
REQ-032 Reset 3 cycles, RGB_ready=1 constant -> RGB_addr 0..16383 on consecutive cycles, gray_addr trails by exactly 1 cycle.
REQ-033 RGB_ready low 5 cycles at k=200 -> RGB_req low, RGB_addr held at 200, no gray write for 200 until resumed.
REQ-034 Pixel p=129 (interior) -> nb_addr sequence 129,0,1,2,128,130,256,257,258; lbp_valid with lbp_addr=129 two cycles after last read.
REQ-035 Pixel p=127 with LBP_BORDER_ZERO_EN -> single cycle lbp_valid=1, lbp_zero=1, no nb_rd; without macro -> no lbp_valid for 127.
REQ-036 Full 128x128 frame with macro -> 16384 lbp_valid pulses (508 lbp_zero), finish rises after 15876*11+508 scan cycles, stays high.
REQ-037 reset asserted during READ of p=5000 -> all outputs 0 same cycle, LOAD restarts at RGB_addr 0, finish low.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP scan controller: FSM states,
// default image geometry and the 3x3 window offset table.
package lbp_pkg;

   localparam int ADDR_W    = 14;
   localparam int DEF_IMG_W = 128;
   localparam int DEF_IMG_H = 128;
   localparam int NB_SLOTS  = 9;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      READ,
      WAIT,
      EMIT,
      BORDER,
      DONE
   } state_t;

   // Raster offset of window slot sel; negative offsets wrap in 14-bit space.
   function automatic addr_t nb_offset(input logic [3:0] sel, input int unsigned w);
      addr_t wv;
      wv = addr_t'(w);
      case (sel)
         4'd1:    nb_offset = -(wv + addr_t'(1));
         4'd2:    nb_offset = -wv;
         4'd3:    nb_offset = -(wv - addr_t'(1));
         4'd4:    nb_offset = -addr_t'(1);
         4'd5:    nb_offset = addr_t'(1);
         4'd6:    nb_offset = wv - addr_t'(1);
         4'd7:    nb_offset = wv;
         4'd8:    nb_offset = wv + addr_t'(1);
         default: nb_offset = '0;
      endcase
   endfunction

endpackage

// File: rtl/lbp_scan_ctrl_if.sv
// Host/datapath-facing signal bundle of the LBP scan controller.
// master = controller side, slave = host/datapath side.
interface lbp_scan_ctrl_if;
   import lbp_pkg::*;

   logic  RGB_ready;
   logic  RGB_req;
   addr_t RGB_addr;
   logic  gray_valid;
   addr_t gray_addr;
   logic  nb_rd;
   addr_t nb_addr;
   logic  [3:0] nb_sel;
   logic  lbp_valid;
   addr_t lbp_addr;
   logic  lbp_zero;
   logic  finish;

   modport master (
      input  RGB_ready,
      output RGB_req, RGB_addr, gray_valid, gray_addr,
             nb_rd, nb_addr, nb_sel, lbp_valid, lbp_addr, lbp_zero, finish
   );

   modport slave (
      output RGB_ready,
      input  RGB_req, RGB_addr, gray_valid, gray_addr,
             nb_rd, nb_addr, nb_sel, lbp_valid, lbp_addr, lbp_zero, finish
   );
endinterface

// File: rtl/lbp_nb_addr_gen.sv
// Combinational window address generator: (pixel, slot) -> gray-buffer
// index, plus a flag telling whether the pixel lies on the image border.
module lbp_nb_addr_gen
   import lbp_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H
) (
   input  addr_t      p,
   input  logic [3:0] sel,
   output addr_t      nb_addr,
   output logic       border
);
   localparam int CW = $clog2(IMG_W);

   addr_t         row;
   logic [CW-1:0] col;

   assign col     = p[CW-1:0];
   assign row     = p >> CW;
   assign nb_addr = p + nb_offset(sel, IMG_W);
   assign border  = (row == '0) || (row == addr_t'(IMG_H-1)) ||
                    (col == '0) || (col == CW'(IMG_W-1));
endmodule

// File: rtl/lbp_scan_ctrl.sv
// LBP frame controller: loads the RGB frame, then walks every pixel through a
// 3x3 gray-buffer read window. Define LBP_BORDER_ZERO_EN to emit zero results for border pixels.
module lbp_scan_ctrl
   import lbp_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H
) (
   input  logic            clk,
   input  logic            reset,
   lbp_scan_ctrl_if.master bus
);
   localparam int    N      = IMG_W * IMG_H;
   localparam addr_t LAST_K = addr_t'(N-1);
`ifdef LBP_BORDER_ZERO_EN
   localparam addr_t FIRST_PIX = '0;
   localparam addr_t LAST_PIX  = addr_t'(N-1);
`else
   localparam addr_t FIRST_PIX = addr_t'(IMG_W+1);
   localparam addr_t LAST_PIX  = addr_t'(N-IMG_W-2);
`endif

   state_t     state_reg, state_next;
   addr_t      k_reg, p_reg, gray_addr_reg;
   addr_t      nb_addr_hold_reg, lbp_addr_hold_reg;
   logic [3:0] sel_reg, nb_sel_hold_reg;
   logic       load_done_reg, gray_valid_reg;

   logic  rgb_req, nb_rd, lbp_valid, lbp_zero, adv, gen_border;
   addr_t p_gen, p_next, gen_addr;
   state_t pix_state;

   // While leaving a pixel the generator looks at p+1 so the next state
   // (and, without border output, the skip distance) is known this cycle.
   assign adv   = (state_reg == EMIT) || (state_reg == BORDER);
   assign p_gen = adv ? p_reg + addr_t'(1) : p_reg;

   lbp_nb_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_addr_gen (
      .p       (p_gen),
      .sel     (sel_reg),
      .nb_addr (gen_addr),
      .border  (gen_border)
   );

   always_comb begin
`ifdef LBP_BORDER_ZERO_EN
      p_next    = p_reg + addr_t'(1);
      pix_state = gen_border ? BORDER : READ;
`else
      p_next    = gen_border ? p_reg + addr_t'(3) : p_reg + addr_t'(1);
      pix_state = READ;
`endif
   end

   always_comb begin
      state_next = state_reg;
      rgb_req    = 1'b0;
      nb_rd      = 1'b0;
      lbp_valid  = 1'b0;
      lbp_zero   = 1'b0;
      case (state_reg)
         IDLE: state_next = LOAD;
         LOAD: begin
            if (!load_done_reg) rgb_req = bus.RGB_ready;
            else                state_next = pix_state;
         end
         READ: begin
            nb_rd = 1'b1;
            if (sel_reg == 4'(NB_SLOTS-1)) state_next = WAIT;
         end
         WAIT: state_next = EMIT;
         EMIT: begin
            lbp_valid  = 1'b1;
            state_next = (p_reg == LAST_PIX) ? DONE : pix_state;
         end
         BORDER: begin
            lbp_valid  = 1'b1;
`ifdef LBP_BORDER_ZERO_EN
            lbp_zero   = 1'b1;
`endif
            state_next = (p_reg == LAST_PIX) ? DONE : pix_state;
         end
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= IDLE;
         k_reg             <= '0;
         p_reg             <= '0;
         sel_reg           <= '0;
         load_done_reg     <= 1'b0;
         gray_valid_reg    <= 1'b0;
         gray_addr_reg     <= '0;
         nb_addr_hold_reg  <= '0;
         nb_sel_hold_reg   <= '0;
         lbp_addr_hold_reg <= '0;
      end else begin
         state_reg      <= state_next;
         gray_valid_reg <= rgb_req;
         if (rgb_req) gray_addr_reg <= k_reg;
         if (state_reg == IDLE) begin
            k_reg         <= '0;
            p_reg         <= FIRST_PIX;
            sel_reg       <= '0;
            load_done_reg <= 1'b0;
         end
         // k parks on the last index so RGB_addr keeps the final request.
         if (rgb_req) begin
            if (k_reg == LAST_K) load_done_reg <= 1'b1;
            else                 k_reg <= k_reg + addr_t'(1);
         end
         if (nb_rd) begin
            sel_reg          <= (sel_reg == 4'(NB_SLOTS-1)) ? 4'd0 : sel_reg + 4'd1;
            nb_addr_hold_reg <= gen_addr;
            nb_sel_hold_reg  <= sel_reg;
         end
         if (lbp_valid) lbp_addr_hold_reg <= p_reg;
         if (adv && state_next != DONE) p_reg <= p_next;
      end
   end

   assign bus.RGB_req    = rgb_req;
   assign bus.RGB_addr   = k_reg;
   assign bus.gray_valid = gray_valid_reg;
   assign bus.gray_addr  = gray_addr_reg;
   assign bus.nb_rd      = nb_rd;
   assign bus.nb_addr    = nb_rd ? gen_addr : nb_addr_hold_reg;
   assign bus.nb_sel     = nb_rd ? sel_reg : nb_sel_hold_reg;
   assign bus.lbp_valid  = lbp_valid;
   assign bus.lbp_addr   = lbp_valid ? p_reg : lbp_addr_hold_reg;
   assign bus.lbp_zero   = lbp_zero;
   assign bus.finish     = (state_reg == DONE);
endmodule
